opcode_fetch_mod: RTL and testbench

OPCODE_FETCH_MOD -- requirements
Module: opcode_fetch_mod

---
 rtl/opcode_fetch_mod.sv | 119 +++++++++++
 tb/tb_opcode_fetch_mod.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/opcode_fetch_mod.sv
// Opcode fetch unit: reads one opcode byte (or a 0xCB prefix plus one byte) from memory
// and holds the 9-bit {prefix_flag, opcode_byte} for the execution stage until exec_done.
module opcode_fetch_mod (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [15:0] pc,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  input  logic        exec_done,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic [8:0]  opcode,
  output logic        opcode_valid
);

  localparam logic [7:0] PREFIX_BYTE = 8'hCB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_PREFIX = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [8:0]  opcode_r;
  logic [8:0]  opcode_next_s;
  logic        opcode_load_s;
  logic        opcode_valid_r;
  logic        mem_rd_s;
  logic        pc_inc_s;

  // Next-state and request decode; mem_ack only matters in the two request states.
  always_comb begin
    state_next_s  = state_r;
    mem_rd_s      = 1'b0;
    pc_inc_s      = 1'b0;
    opcode_load_s = 1'b0;
    opcode_next_s = opcode_r;
    case (state_r)
      ST_IDLE: begin
        if (fetch_en) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        mem_rd_s = 1'b1;
        if (mem_ack) begin
          pc_inc_s = 1'b1;
          if (mem_data == PREFIX_BYTE) begin
            state_next_s = ST_PREFIX;
          end else begin
            opcode_load_s = 1'b1;
            opcode_next_s = {1'b0, mem_data};
            state_next_s  = ST_HOLD;
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_PREFIX: begin
        // A second 0xCB here is an ordinary operand byte: prefixes never nest.
        mem_rd_s = 1'b1;
        if (mem_ack) begin
          pc_inc_s      = 1'b1;
          opcode_load_s = 1'b1;
          opcode_next_s = {1'b1, mem_data};
          state_next_s  = ST_HOLD;
        end else begin
          state_next_s = ST_PREFIX;
        end
      end
      ST_HOLD: begin
        if (exec_done) begin
          if (fetch_en) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, opcode and valid registers; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      opcode_r       <= 9'h000;
      opcode_valid_r <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      opcode_valid_r <= (state_next_s == ST_HOLD);
      if (opcode_load_s) begin
        opcode_r <= opcode_next_s;
      end else begin
        opcode_r <= opcode_r;
      end
    end
  end

  // Reset masks the combinational request so an interrupted fetch never bumps the PC.
  assign mem_rd       = mem_rd_s & ~rst;
  assign pc_inc       = pc_inc_s & ~rst;
  assign mem_addr     = mem_rd ? pc : 16'h0000;
  assign opcode       = opcode_r;
  assign opcode_valid = opcode_valid_r;

endmodule

// File: tb/tb_opcode_fetch_mod.sv
// Directed bench for opcode_fetch_mod: one cycle-by-cycle vector table plus a
// hand-written reset-during-prefix sequence with pc_inc pulse counting.
module tb_opcode_fetch_mod;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] pc;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        exec_done;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        pc_inc;
  logic [8:0]  opcode;
  logic        opcode_valid;

  int total;
  int bad;
  int inc_cnt;

  typedef struct {
    logic        rst;
    logic        fen;
    logic [15:0] pc;
    logic [7:0]  data;
    logic        ack;
    logic        done;
    logic [15:0] e_addr;
    logic        e_rd;
    logic        e_inc;
    logic [8:0]  e_op;
    logic        e_valid;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  opcode_fetch_mod dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .pc           (pc),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack),
    .exec_done    (exec_done),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .pc_inc       (pc_inc),
    .opcode       (opcode),
    .opcode_valid (opcode_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then move to the falling edge for sampling.
  task automatic drive(input logic r, input logic fen, input logic [15:0] p,
                       input logic [7:0] d, input logic a, input logic dn);
    rst = r; fetch_en = fen; pc = p; mem_data = d; mem_ack = a; exec_done = dn;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    inc_cnt = 0;

    //            rst   fen   pc        data   ack   done  | addr      rd    inc   opcode  valid
    vecs[0]  = '{1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0100, 8'h3E, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h0100, 8'h3E, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 9'h000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0101, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h03E, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0101, 8'h55, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h03E, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 16'h0101, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h03E, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0200, 8'hCB, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b1, 9'h03E, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0201, 8'h37, 1'b0, 1'b1, 16'h0201, 1'b1, 1'b0, 9'h03E, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0201, 8'h37, 1'b1, 1'b0, 16'h0201, 1'b1, 1'b1, 9'h03E, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0202, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h137, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0202, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h137, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 16'h0202, 8'h11, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h137, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h137, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 16'h0300, 8'hCB, 1'b1, 1'b0, 16'h0300, 1'b1, 1'b1, 9'h137, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 16'h0301, 8'hCB, 1'b1, 1'b0, 16'h0301, 1'b1, 1'b1, 9'h137, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 16'h0302, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h1CB, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 16'h0302, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h1CB, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 16'h0400, 8'h00, 1'b0, 1'b1, 16'h0400, 1'b1, 1'b0, 9'h1CB, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 16'h0400, 8'hCB, 1'b0, 1'b1, 16'h0400, 1'b1, 1'b0, 9'h1CB, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b0, 16'h0400, 1'b1, 1'b0, 9'h1CB, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 16'h0400, 8'hA7, 1'b1, 1'b0, 16'h0400, 1'b1, 1'b1, 9'h1CB, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 16'h0401, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0A7, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 16'h0401, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 9'h0A7, 1'b1};
    vecs[23] = '{1'b1, 1'b1, 16'h0401, 8'h12, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h0A7, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 16'h0401, 8'h12, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 9'h000, 1'b0};

    // Initial reset cycle brings the DUT out of X before the table starts.
    rst = 1'b1; fetch_en = 1'b0; pc = 16'h0000; mem_data = 8'h00; mem_ack = 1'b0; exec_done = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].fen, vecs[i].pc, vecs[i].data, vecs[i].ack, vecs[i].done);
      chk("mem_addr",     i, mem_addr,              vecs[i].e_addr);
      chk("mem_rd",       i, {15'd0, mem_rd},       {15'd0, vecs[i].e_rd});
      chk("pc_inc",       i, {15'd0, pc_inc},       {15'd0, vecs[i].e_inc});
      chk("opcode",       i, {7'd0, opcode},        {7'd0, vecs[i].e_op});
      chk("opcode_valid", i, {15'd0, opcode_valid}, {15'd0, vecs[i].e_valid});
      step();
    end

    // Reset arriving in PREFIX together with mem_ack: the fetch must vanish.
    drive(1'b0, 1'b1, 16'h0500, 8'h00, 1'b0, 1'b0);
    if (pc_inc) inc_cnt++;
    step();
    drive(1'b0, 1'b1, 16'h0500, 8'h5A, 1'b1, 1'b0);
    if (pc_inc) inc_cnt++;
    step();
    drive(1'b0, 1'b1, 16'h0501, 8'h00, 1'b0, 1'b1);
    if (pc_inc) inc_cnt++;
    chk("seq_hold_op", 0, {7'd0, opcode}, 16'h005A);
    step();
    drive(1'b0, 1'b1, 16'h0600, 8'hCB, 1'b1, 1'b0);
    if (pc_inc) inc_cnt++;
    chk("seq_fetch_rd", 1, {15'd0, mem_rd}, 16'h0001);
    step();
    drive(1'b1, 1'b1, 16'h0601, 8'h44, 1'b1, 1'b0);
    if (pc_inc) inc_cnt++;
    chk("seq_rst_inc", 2, {15'd0, pc_inc}, 16'h0000);
    chk("seq_rst_rd",  2, {15'd0, mem_rd}, 16'h0000);
    step();
    drive(1'b0, 1'b0, 16'h0601, 8'h44, 1'b1, 1'b0);
    if (pc_inc) inc_cnt++;
    chk("seq_post_op",    3, {7'd0, opcode},        16'h0000);
    chk("seq_post_valid", 3, {15'd0, opcode_valid}, 16'h0000);
    chk("seq_post_rd",    3, {15'd0, mem_rd},       16'h0000);
    chk("seq_post_inc",   3, {15'd0, pc_inc},       16'h0000);
    chk("seq_post_addr",  3, mem_addr,              16'h0000);
    step();
    // Still idle one cycle later: the aborted prefix fetch did not resume.
    drive(1'b0, 1'b0, 16'h0601, 8'h44, 1'b1, 1'b1);
    if (pc_inc) inc_cnt++;
    chk("seq_idle_rd", 4, {15'd0, mem_rd}, 16'h0000);
    chk("seq_inc_cnt", 5, inc_cnt[15:0],   16'h0002);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
